logic_capture: RTL and testbench
================================

Name: logic_capture

Overview:
- Multi-channel logic-analyser capture engine. Next generation of the single-channel sync-and-capture slice.
- Samples CH input lines every clock and waits for a selectable trigger on one chosen channel. It then records np samples of all channels into an internal sample memory.
- The display/readout side reads the memory through a registered read port. Sits between the input pins and the display frame builder.

Parameters:
- CH, 8, number of captured channels (1..32)
- DEPTH, 960, sample memory depth in samples; max points per capture
- BASE, 200000000, stable-level threshold base; threshold = BASE >> n
- AW, $clog2(DEPTH), address/count width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in  in  CH  sampled input lines
- arm  in  1  one-cycle pulse: start a new capture
- trig_mode  in  2  0=stable-level sync, 1=rising edge, 2=falling edge, 3=immediate
- trig_ch  in  $clog2(CH) (min 1)  channel index used for triggering
- n  in  5  threshold shift for mode 0
- np  in  AW  requested points; latched at arm
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- count  out  AW+1  samples written in current/last capture
- rd_addr  in  AW  read address
- rd_data  out  CH  mem[rd_addr], registered

Behaviour:
- Reset: state=IDLE, busy=0, done=0, count=0, rd_data=0, stable counter=0, edge history=0. Memory contents are not cleared.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE + arm: latch np_l, trig_mode, trig_ch, threshold=BASE>>n. Clear count and stable counter. Go to ARMED. done drops the cycle after arm.
- np_l = DEPTH if np==0 or np>DEPTH, else np.
- ARMED, trigger evaluated every cycle on t = in[trig_ch] with p = t registered one cycle earlier:
  - mode 0: 32-bit saturating counter. Cleared when t!=p, else incremented. Trigger when counter >= threshold. Threshold 0 triggers on the first ARMED cycle.
  - mode 1: trigger when p=0, t=1.
  - mode 2: trigger when p=1, t=0.
  - mode 3: trigger on the first ARMED cycle.
- Edge history p is updated in every state, so an edge straddling arm is detected.
- Trigger -> CAPTURE on the next edge. CAPTURE writes mem[count]=in each cycle and count increments.
  - Index 0 holds the input of the first CAPTURE cycle, i.e. the cycle after the trigger condition was true.
- When count reaches np_l: go to DONE. done=1 and busy=0 in the same cycle count==np_l becomes visible.
- arm in ARMED or CAPTURE is ignored. arm in DONE restarts the capture.
- trig_ch >= CH: trigger channel forced to 0.
- rd_data = mem[rd_addr] one cycle after rd_addr. Reads are legal in any state. During CAPTURE, unwritten locations return the previous capture's data.
- rst mid-capture: immediate return to IDLE, count=0. Partially written memory is left as is.

Optional Feature:
- Macro: LOGIC_CAPTURE_INSYNC_EN.
- Defined: `in` passes through a 2-flop synchroniser per channel before trigger logic and memory. All trigger and capture timing is shifted 2 cycles later relative to pins. Synchroniser flops reset to 0.
- Undefined: `in` is used directly, with the timing given above.

Test Plan:
- Mode 3, np=4, in counts 0x00,0x01,0x02..., arm at cycle 10 -> ARMED cycle 11, CAPTURE cycles 12..15 storing in values of cycles 12..15. done=1 and count=4 at cycle 16; rd_addr 0..3 return those values.
- Mode 1, trig_ch=3, in[3] rises at cycle 50 -> mem[0] = in at cycle 51. Falling edges and other-channel edges are ignored before cycle 50.
- Mode 0, BASE=1000, n=2 (threshold 250), in[trig_ch] toggles every 100 cycles then holds high -> no trigger while toggling. Trigger after 250 consecutive stable cycles; capture starts the next cycle.
- np=0 and np=DEPTH+5 -> count ends at DEPTH (960); no write beyond DEPTH-1.
- Second arm during CAPTURE -> ignored, count completes to np. rst asserted at count=7 -> IDLE, busy=0, done=0, count=0 next cycle.
- With LOGIC_CAPTURE_INSYNC_EN, mode 1 edge on pin at cycle 50 -> mem[0] holds the pin value of cycle 51, and capture starts 2 cycles later than without the macro.

Source files
------------

// File: rtl/logic_capture.sv
// Multi-channel logic-analyser capture engine: trigger on one channel, record np samples of all channels.
// Optional macro LOGIC_CAPTURE_INSYNC_EN adds a 2-flop input synchroniser ahead of trigger and memory.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | evaluating trigger condition every cycle
// CAPTURE | writing one sample per cycle into mem[count]
// DONE    | capture complete, memory holds np_l samples
module logic_capture #(
    parameter int  CH    = 8,
    parameter int  DEPTH = 960,
    parameter int  BASE  = 200000000,
    parameter int  AW    = $clog2(DEPTH),
    localparam int TW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    input  logic          arm,
    input  logic [1:0]    trig_mode,
    input  logic [TW-1:0] trig_ch,
    input  logic [4:0]    n,
    input  logic [AW-1:0] np,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    input  logic [AW-1:0] rd_addr,
    output logic [CH-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [31:0] BASE_W  = 32'(BASE);
    localparam logic [TW:0] CH_W    = (TW+1)'(CH);

    state_t        state;
    logic [CH-1:0] in_s;
    logic [CH-1:0] in_prev;
    logic [AW:0]   np_l;
    logic [1:0]    mode_l;
    logic [TW-1:0] ch_l;
    logic [31:0]   thr;
    logic [31:0]   stable_cnt;
    logic          t;
    logic          p;
    logic          trig;
    logic [CH-1:0] mem [0:DEPTH-1];

`ifdef LOGIC_CAPTURE_INSYNC_EN
    logic [CH-1:0] sync_q1;
    logic [CH-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in;
            sync_q2 <= sync_q1;
        end
    end

    assign in_s = sync_q2;
`else
    assign in_s = in;
`endif

    // History is kept for every channel so an edge straddling arm is seen on the newly selected channel.
    always_comb begin
        t    = in_s[ch_l];
        p    = in_prev[ch_l];
        trig = 1'b0;
        case (mode_l)
            2'd0:    trig = (stable_cnt >= thr);
            2'd1:    trig = !p && t;
            2'd2:    trig = p && !t;
            default: trig = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            stable_cnt <= '0;
            in_prev    <= '0;
            np_l       <= DEPTH_W;
            mode_l     <= 2'd0;
            ch_l       <= '0;
            thr        <= '0;
        end else begin
            in_prev <= in_s;
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        if (np == '0 || {1'b0, np} > DEPTH_W)
                            np_l <= DEPTH_W;
                        else
                            np_l <= {1'b0, np};
                        mode_l     <= trig_mode;
                        ch_l       <= ({1'b0, trig_ch} < CH_W) ? trig_ch : '0;
                        thr        <= BASE_W >> n;
                        count      <= '0;
                        stable_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    if (t != p)
                        stable_cnt <= '0;
                    else if (stable_cnt != '1)
                        stable_cnt <= stable_cnt + 32'd1;
                    if (trig)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    count <= count + 1'b1;
                    if ((count + 1'b1) == np_l) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample memory is not reset; a reset mid-capture leaves partial contents in place.
    always_ff @(posedge clk) begin
        if (!rst && state == CAPTURE)
            mem[count[AW-1:0]] <= in_s;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < DEPTH_W)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_logic_capture.sv
// Self-checking bench for logic_capture: table of capture scenarios plus hand-written corner sequences.
// Expected samples go into a scoreboard queue as they are driven and are compared on readback.
module tb_logic_capture;

    localparam int CH    = 8;
    localparam int DEPTH = 960;
    localparam int BASE  = 1000;
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = 3;
    localparam int HN    = 16384;
`ifdef LOGIC_CAPTURE_INSYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          clk;
    logic          rst;
    logic [CH-1:0] in;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [TW-1:0] trig_ch;
    logic [4:0]    n;
    logic [AW-1:0] np;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr;
    logic [CH-1:0] rd_data;

    logic_capture #(.CH(CH), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .arm       (arm),
        .trig_mode (trig_mode),
        .trig_ch   (trig_ch),
        .n         (n),
        .np        (np),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         ch;
        int         nsh;
        int         npts;
        int         delay;
        int         exp_n;
    } row_t;

    row_t          rows [9];
    int            cyc;
    int            checks;
    int            errors;
    logic [CH-1:0] hist [0:HN-1];
    logic [CH-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Records the pin value of the current cycle, then moves to just after the next rising edge.
    task automatic step();
        hist[cyc % HN] = in;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [CH-1:0] rnd();
        return CH'($urandom);
    endfunction

    // Called in the cycle that should be the first CAPTURE cycle.
    task automatic run_capture(input int exp_n, input int arm_at, input int rst_at);
        for (int i = 0; i < exp_n; i++) begin
            check("capture_progress", {busy, done, count}, {1'b1, 1'b0, (AW+1)'(i)});
            in = rnd();
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("rst_mid_capture", {busy, done, count}, '0);
                check("rst_rd_data", rd_data, '0);
                return;
            end
            arm = (i == arm_at);
            if (i == arm_at) np = AW'(2);
            step();
            arm = 1'b0;
            exp_q.push_back(hist[(cyc - 1 - SYNC) % HN]);
        end
        check("done_flags", {busy, done, count}, {1'b0, 1'b1, (AW+1)'(exp_n)});
        in = rnd();
        step();
        check("done_hold", {busy, done, count}, {1'b0, 1'b1, (AW+1)'(exp_n)});
    endtask

    task automatic readback(input int n_rd);
        for (int a = 0; a < n_rd; a++) begin
            rd_addr = AW'(a);
            in = rnd();
            step();
            check("rd_data", rd_data, exp_q.pop_front());
        end
    endtask

    task automatic run_row(input row_t r, input int arm_at, input int rst_at);
        logic [CH-1:0] v;
        bit            edge_mode;
        logic          lvl0;
        int            a, e, start;
        edge_mode = (r.mode == 2'd1 || r.mode == 2'd2);
        lvl0      = (r.mode == 2'd2);
        // Idle at the opposite level so the arm-time transition is a wrong-direction edge.
        for (int k = 0; k < 3; k++) begin
            v = rnd();
            v[r.ch] = ~lvl0;
            in = v;
            step();
        end
        a     = cyc;
        e     = a + 1 + r.delay;
        start = edge_mode ? e + 1 + SYNC : a + 2;
        v = rnd();
        v[r.ch] = lvl0;
        in        = v;
        arm       = 1'b1;
        trig_mode = r.mode;
        trig_ch   = TW'(r.ch);
        n         = 5'(r.nsh);
        np        = AW'(r.npts);
        step();
        arm = 1'b0;
        while (cyc < start) begin
            if (cyc == a + 1)
                check("armed_busy_done", {busy, done}, 2'b10);
            if (cyc == start - 1)
                check("pre_trigger", {busy, done, count}, {1'b1, 1'b0, (AW+1)'(0)});
            v = rnd();
            if (edge_mode) v[r.ch] = (cyc < e) ? lvl0 : ~lvl0;
            in = v;
            step();
        end
        run_capture(r.exp_n, arm_at, rst_at);
        readback((rst_at >= 0) ? rst_at : r.exp_n);
    endtask

    task automatic run_stable_level();
        logic [CH-1:0] v;
        int            a, rel, start;
        for (int k = 0; k < 3; k++) begin
            v = rnd();
            v[4] = 1'b0;
            in = v;
            step();
        end
        a     = cyc;
        start = a + 502 + SYNC;
        v = rnd();
        v[4] = 1'b0;
        in        = v;
        arm       = 1'b1;
        trig_mode = 2'd0;
        trig_ch   = TW'(4);
        n         = 5'd2;
        np        = AW'(3);
        step();
        arm = 1'b0;
        while (cyc < start) begin
            rel = cyc - a;
            if (cyc == a + 1)
                check("stable_armed", {busy, done}, 2'b10);
            if (cyc == a + 400)
                check("stable_no_trigger_toggling", {busy, done, count}, {1'b1, 1'b0, (AW+1)'(0)});
            if (cyc == start - 1)
                check("stable_pre_trigger", {busy, done, count}, {1'b1, 1'b0, (AW+1)'(0)});
            v = rnd();
            v[4] = (rel < 50) ? 1'b0 : (rel < 150) ? 1'b1 : (rel < 250) ? 1'b0 : 1'b1;
            in = v;
            step();
        end
        run_capture(3, -1, -1);
        readback(3);
    endtask

    initial begin
        row_t hr;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in        = '0;
        arm       = 1'b0;
        trig_mode = 2'd0;
        trig_ch   = '0;
        n         = '0;
        np        = '0;
        rd_addr   = '0;

        //            mode  ch nsh npts       delay exp_n
        rows[0] = '{2'd3, 0, 0,  4,         0, 4};
        rows[1] = '{2'd1, 3, 0,  5,         0, 5};
        rows[2] = '{2'd1, 3, 0,  6,         7, 6};
        rows[3] = '{2'd2, 5, 0,  3,         4, 3};
        rows[4] = '{2'd0, 6, 10, 2,         0, 2};
        rows[5] = '{2'd3, 7, 0,  1,         0, 1};
        rows[6] = '{2'd3, 2, 0,  0,         0, DEPTH};
        rows[7] = '{2'd2, 7, 0,  DEPTH + 5, 1, DEPTH};
        rows[8] = '{2'd1, 0, 0,  DEPTH - 1, 2, DEPTH - 1};

        step();
        step();
        check("reset_flags", {busy, done, count}, '0);
        check("reset_rd_data", rd_data, '0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in = rnd();
            step();
        end
        check("idle_after_reset", {busy, done, count}, '0);

        for (int r = 0; r < 9; r++)
            run_row(rows[r], -1, -1);

        run_stable_level();

        hr = '{2'd3, 1, 0, 10, 0, 10};
        run_row(hr, 3, -1);

        hr = '{2'd3, 6, 0, 20, 0, 20};
        run_row(hr, -1, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
